// File: rtl/scan_mux_pkg.sv
// Shared types and constants for the scanning channel multiplexer.
// Holds the FSM state encoding, mode encoding and the index-width helper.
package scan_mux_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_MANUAL = 2'd1,
        ST_SCAN   = 2'd2
    } state_t;

    localparam logic MODE_MANUAL = 1'b0;
    localparam logic MODE_SCAN   = 1'b1;

    // Channel-index width; never narrower than one bit.
    function automatic int sw_of(input int n);
        return ($clog2(n) > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/scan_mux_dwell_counter.sv
// Dwell counter: counts 0..DWELL-1 while run is high and flags the last count.
// A clear always wins, so each new channel visit starts from zero.
module dwell_counter #(
    parameter int DWELL = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic run,
    output logic tc
);
    localparam int CW = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [CW-1:0] LAST = CW'(DWELL - 1);

    logic [CW-1:0] cnt_reg;
    logic [CW-1:0] cnt_next;

    assign tc = run && (cnt_reg == LAST);

    always_comb begin
        cnt_next = cnt_reg;
        if (clear) begin
            cnt_next = '0;
        end else if (run) begin
            cnt_next = tc ? '0 : cnt_reg + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_reg <= '0;
        end else begin
            cnt_reg <= cnt_next;
        end
    end

endmodule

// File: rtl/scan_mux.sv
// Registered N-way channel multiplexer with manual select and timed auto-scan.
// Outputs reflect the mode requested on the same edge, giving one-cycle latency.
module scan_mux
    import scan_mux_pkg::*;
#(
    parameter int W     = 8,
    parameter int N     = 4,
    parameter int DWELL = 4,
    localparam int SW   = sw_of(N)
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [N*W-1:0] din,
    input  logic           en,
    input  logic           mode,
    input  logic [SW-1:0]  sel,
    output logic [W-1:0]   dout,
    output logic [SW-1:0]  ch,
    output logic           out_valid,
    output logic           wrap,
    output logic           sel_err
);
    localparam logic [SW-1:0] LAST_CH = SW'(N - 1);

    state_t        state_reg, state_next;
    logic [W-1:0]  dout_reg, dout_next;
    logic [SW-1:0] ch_reg, ch_next;
    logic [SW-1:0] ch_cur_reg, ch_cur_next;
    logic          valid_reg, valid_next;
    logic          wrap_reg, wrap_next;
    logic          sel_err_reg, sel_err_next;

    logic          scan_next;
    logic          tc;
    logic          sel_ok;
    logic [SW-1:0] pick;
    logic [W-1:0]  picked;
    int            base;

    assign scan_next = (state_next == ST_SCAN);

    dwell_counter #(
        .DWELL(DWELL)
    ) u_dwell (
        .clk  (clk),
        .rst_n(rst_n),
        .clear(!scan_next),
        .run  (scan_next),
        .tc   (tc)
    );

    always_comb begin
        state_next = ST_IDLE;
        if (en) begin
            state_next = (mode == MODE_SCAN) ? ST_SCAN : ST_MANUAL;
        end
    end

    always_comb begin
        sel_ok       = int'(sel) < N;
        pick         = scan_next ? ch_cur_reg : sel;
        base         = int'(pick) * W;
        picked       = din[base +: W];
        dout_next    = dout_reg;
        ch_next      = ch_reg;
        ch_cur_next  = ch_cur_reg;
        valid_next   = 1'b0;
        wrap_next    = 1'b0;
        sel_err_next = 1'b0;

        case (state_next)
            ST_MANUAL: begin
                if (sel_ok) begin
                    dout_next  = picked;
                    ch_next    = sel;
                    valid_next = 1'b1;
                end else begin
                    sel_err_next = 1'b1;
                end
            end
            ST_SCAN: begin
                dout_next  = picked;
                ch_next    = ch_cur_reg;
                valid_next = 1'b1;
                // ch_cur only sits at 0 right after ch showed N-1 when the scan just wrapped.
                wrap_next  = (state_reg == ST_SCAN) && (ch_reg == LAST_CH) && (ch_cur_reg == '0);
                if (tc) begin
                    ch_cur_next = (ch_cur_reg == LAST_CH) ? '0 : ch_cur_reg + SW'(1);
                end
            end
            default: ;
        endcase

        // Outside SCAN the scan pointer follows ch, so a later scan starts there.
        if (!scan_next) begin
            ch_cur_next = ch_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= ST_IDLE;
            dout_reg    <= '0;
            ch_reg      <= '0;
            ch_cur_reg  <= '0;
            valid_reg   <= 1'b0;
            wrap_reg    <= 1'b0;
            sel_err_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            dout_reg    <= dout_next;
            ch_reg      <= ch_next;
            ch_cur_reg  <= ch_cur_next;
            valid_reg   <= valid_next;
            wrap_reg    <= wrap_next;
            sel_err_reg <= sel_err_next;
        end
    end

    assign dout      = dout_reg;
    assign ch        = ch_reg;
    assign out_valid = valid_reg;
    assign wrap      = wrap_reg;
    assign sel_err   = sel_err_reg;

endmodule

// File: tb/tb_scan_mux.sv
// Self-checking bench for scan_mux: directed vector table, corner sequences,
// and randomized traffic against a cycle-level behavioural reference model.
module tb_scan_mux;
    localparam int W = 8;
    localparam int N = 3;
    localparam int DWELL = 2;
    localparam logic [23:0] D0 = 24'h332211;
    localparam logic [23:0] D1 = 24'h33AA11;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic           rst_n;
    logic [N*W-1:0] din;
    logic           en, mode;
    logic [1:0]     sel;
    logic [W-1:0]   dout;
    logic [1:0]     ch;
    logic           out_valid, wrap, sel_err;

    logic [31:0] din_b;
    logic        en_b, mode_b;
    logic [1:0]  sel_b;
    logic [7:0]  dout_b;
    logic [1:0]  ch_b;
    logic        valid_b, wrap_b, err_b;

    scan_mux #(.W(W), .N(N), .DWELL(DWELL)) dut (
        .clk(clk), .rst_n(rst_n), .din(din), .en(en), .mode(mode), .sel(sel),
        .dout(dout), .ch(ch), .out_valid(out_valid), .wrap(wrap), .sel_err(sel_err)
    );

    scan_mux #(.W(8), .N(4), .DWELL(1)) dut_b (
        .clk(clk), .rst_n(rst_n), .din(din_b), .en(en_b), .mode(mode_b), .sel(sel_b),
        .dout(dout_b), .ch(ch_b), .out_valid(valid_b), .wrap(wrap_b), .sel_err(err_b)
    );

    int n_checks = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic [7:0] e_dout, input logic [1:0] e_ch,
                             input logic e_v, input logic e_w, input logic e_e);
        chk({tag, " dout"}, 32'(dout), 32'(e_dout));
        chk({tag, " ch"}, 32'(ch), 32'(e_ch));
        chk({tag, " out_valid"}, 32'(out_valid), 32'(e_v));
        chk({tag, " wrap"}, 32'(wrap), 32'(e_w));
        chk({tag, " sel_err"}, 32'(sel_err), 32'(e_e));
    endtask

    // Reference model: tracks scan position in whole dwell periods, not counter states.
    logic [7:0] m_dout;
    int         m_ch, m_pos, m_ticks;
    logic       m_valid, m_wrap, m_err, m_scanning, m_wrap_pend;

    function automatic logic [7:0] chan(input logic [23:0] d, input int idx);
        return d[idx*8 +: 8];
    endfunction

    task automatic model_reset();
        m_dout = 8'h00; m_ch = 0; m_valid = 0; m_wrap = 0; m_err = 0;
        m_scanning = 0; m_pos = 0; m_ticks = 0; m_wrap_pend = 0;
    endtask

    task automatic model_step(input logic [23:0] d, input logic e, input logic m, input int s);
        m_valid = 0; m_wrap = 0; m_err = 0;
        if (!e) begin
            m_scanning = 0;
        end else if (!m) begin
            m_scanning = 0;
            if (s < N) begin
                m_dout = chan(d, s); m_ch = s; m_valid = 1;
            end else begin
                m_err = 1;
            end
        end else begin
            if (!m_scanning) begin
                m_scanning = 1; m_pos = m_ch; m_ticks = 0; m_wrap_pend = 0;
            end else begin
                m_wrap = m_wrap_pend; m_wrap_pend = 0;
            end
            m_dout = chan(d, m_pos); m_ch = m_pos; m_valid = 1;
            m_ticks++;
            if (m_ticks == DWELL) begin
                m_ticks = 0;
                if (m_pos == N - 1) begin
                    m_pos = 0; m_wrap_pend = 1;
                end else begin
                    m_pos++;
                end
            end
        end
    endtask

    typedef struct {
        logic        en;
        logic        mode;
        logic [1:0]  sel;
        logic [23:0] din;
        logic [7:0]  dout;
        logic [1:0]  ch;
        logic        valid;
        logic        wrap;
        logic        err;
    } vec_t;

    vec_t vq[$];

    task automatic add(input logic e, input logic m, input logic [1:0] s, input logic [23:0] d,
                       input logic [7:0] o, input logic [1:0] c, input logic v, input logic w,
                       input logic x);
        vec_t r;
        r.en = e; r.mode = m; r.sel = s; r.din = d;
        r.dout = o; r.ch = c; r.valid = v; r.wrap = w; r.err = x;
        vq.push_back(r);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        en = 1'b0; mode = 1'b0; sel = 2'd0; din = D0;
        en_b = 1'b0; mode_b = 1'b0; sel_b = 2'd0; din_b = 32'h44332211;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        int wraps;

        // Scan from reset, mode switches, manual select, en drop/resume, din tracking.
        add(1, 1, 0, D0, 8'h11, 0, 1, 0, 0);
        add(1, 1, 0, D0, 8'h11, 0, 1, 0, 0);
        add(1, 1, 0, D0, 8'h22, 1, 1, 0, 0);
        add(1, 1, 0, D0, 8'h22, 1, 1, 0, 0);
        add(1, 1, 0, D0, 8'h33, 2, 1, 0, 0);
        add(1, 1, 0, D0, 8'h33, 2, 1, 0, 0);
        add(1, 1, 0, D0, 8'h11, 0, 1, 1, 0);
        add(1, 1, 0, D0, 8'h11, 0, 1, 0, 0);
        add(1, 1, 0, D0, 8'h22, 1, 1, 0, 0);
        add(1, 0, 0, D0, 8'h11, 0, 1, 0, 0);
        add(1, 1, 0, D0, 8'h11, 0, 1, 0, 0);
        add(1, 1, 0, D0, 8'h11, 0, 1, 0, 0);
        add(1, 1, 0, D0, 8'h22, 1, 1, 0, 0);
        add(1, 0, 2, D0, 8'h33, 2, 1, 0, 0);
        add(1, 0, 3, D0, 8'h33, 2, 0, 0, 1);
        add(0, 0, 0, D0, 8'h33, 2, 0, 0, 0);
        add(1, 1, 0, D0, 8'h33, 2, 1, 0, 0);
        add(1, 1, 0, D0, 8'h33, 2, 1, 0, 0);
        add(1, 1, 0, D0, 8'h11, 0, 1, 1, 0);
        add(0, 1, 0, D0, 8'h11, 0, 0, 0, 0);
        add(1, 1, 0, D0, 8'h11, 0, 1, 0, 0);
        add(1, 1, 0, D0, 8'h11, 0, 1, 0, 0);
        add(1, 1, 0, D0, 8'h22, 1, 1, 0, 0);
        add(1, 1, 0, D1, 8'hAA, 1, 1, 0, 0);

        do_reset();
        #1;
        check_all("reset", 8'h00, 2'd0, 1'b0, 1'b0, 1'b0);

        foreach (vq[i]) begin
            en = vq[i].en; mode = vq[i].mode; sel = vq[i].sel; din = vq[i].din;
            @(posedge clk);
            #1;
            $display("vec %0d en=%0b mode=%0b sel=%0d -> dout=%h ch=%0d v=%0b w=%0b e=%0b",
                     i, en, mode, sel, dout, ch, out_valid, wrap, sel_err);
            check_all($sformatf("vec%0d", i), vq[i].dout, vq[i].ch, vq[i].valid,
                      vq[i].wrap, vq[i].err);
        end

        // Asynchronous reset while scanning channel 2.
        en = 1'b1; mode = 1'b1; din = D0;
        @(posedge clk);
        #1;
        chk("pre-reset ch", 32'(ch), 32'd2);
        #2;
        rst_n = 1'b0;
        #1;
        $display("async reset mid-scan -> dout=%h ch=%0d v=%0b", dout, ch, out_valid);
        check_all("async_rst", 8'h00, 2'd0, 1'b0, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        chk("post-release valid", 32'(out_valid), 32'd0);
        @(posedge clk);
        #1;
        $display("first edge after release -> dout=%h ch=%0d v=%0b", dout, ch, out_valid);
        check_all("rst_resume", 8'h11, 2'd0, 1'b1, 1'b0, 1'b0);

        // Randomized traffic against the reference model.
        do_reset();
        model_reset();
        mode = 1'b1;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(7) == 0) mode = ~mode;
            en = ($urandom_range(9) != 0);
            sel = 2'($urandom_range(3));
            din = 24'($urandom);
            @(posedge clk);
            model_step(din, en, mode, int'(sel));
            #1;
            $display("rnd %0d en=%0b mode=%0b sel=%0d -> dout=%h ch=%0d v=%0b w=%0b e=%0b",
                     i, en, mode, sel, dout, ch, out_valid, wrap, sel_err);
            check_all($sformatf("rnd%0d", i), m_dout, 2'(m_ch), m_valid, m_wrap, m_err);
        end

        // DWELL=1, N=4: one channel per cycle, wrap on cycles 4 and 8 after entry.
        en = 1'b0;
        en_b = 1'b1; mode_b = 1'b1; din_b = 32'h44332211;
        wraps = 0;
        for (int k = 0; k < 12; k++) begin
            @(posedge clk);
            #1;
            $display("dwell1 cycle %0d -> ch=%0d dout=%h wrap=%0b", k, ch_b, dout_b, wrap_b);
            chk($sformatf("dwell1 ch c%0d", k), 32'(ch_b), 32'(k % 4));
            chk($sformatf("dwell1 dout c%0d", k), 32'(dout_b), 32'((k % 4 + 1) * 8'h11));
            chk($sformatf("dwell1 wrap c%0d", k), 32'(wrap_b), 32'(k == 4 || k == 8));
            if (wrap_b) wraps++;
        end
        chk("dwell1 wrap count", 32'(wraps), 32'd2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
